// File: rtl/gray_ptr_bank.sv
// Multi-channel binary/Gray pointer bank with registered full/empty flags.
// Define GRAY_PTR_ALMOST_EN to build the almost-full/almost-empty logic.
module gray_ptr_bank #(
  parameter int ADDR_W    = 3,
  parameter int CHANNELS  = 1,
  parameter int MODE      = 0,
  parameter int ALMOST_TH = 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [CHANNELS-1:0]          inc_i,
  input  logic [CHANNELS-1:0]          en_i,
  input  logic [CHANNELS-1:0]          clr_i,
  input  logic [CHANNELS*(ADDR_W+1)-1:0] rptr_i,
  output logic [CHANNELS*ADDR_W-1:0]   addr_o,
  output logic [CHANNELS*(ADDR_W+1)-1:0] ptr_o,
  output logic [CHANNELS*(ADDR_W+1)-1:0] next_ptr_o,
  output logic [CHANNELS-1:0]          flag_o,
  output logic [CHANNELS-1:0]          wrap_o,
  output logic [CHANNELS-1:0]          almost_o
);

  localparam int PW = ADDR_W + 1;
  localparam logic FLAG_RST = (MODE != 0);

  genvar c;
  generate
    for (c = 0; c < CHANNELS; c++) begin : g_ch
      logic [PW-1:0] bin_q;
      logic [PW-1:0] gray_q;
      logic [PW-1:0] bin_nx;
      logic [PW-1:0] gray_nx;
      logic [PW-1:0] rptr;
      logic [PW-1:0] full_cmp;
      logic          inc_eff;
      logic          flag_q;
      logic          wrap_q;
      logic          alm_q;
      logic          flag_nx;
      logic          wrap_nx;
      logic          alm_nx;

      assign rptr    = rptr_i[c*PW +: PW];
      assign inc_eff = inc_i[c] & en_i[c] & ~flag_q;

      always_comb begin
        bin_nx = bin_q + PW'(inc_eff);
        if (clr_i[c]) bin_nx = '0;
        gray_nx = bin_nx ^ (bin_nx >> 1);
      end

      // Full when the pointers differ by exactly one lap
      assign full_cmp = {~rptr[PW-1:PW-2], rptr[PW-3:0]};

      always_comb begin
        if (MODE == 0) flag_nx = (gray_nx == full_cmp);
        else           flag_nx = (gray_nx == rptr);
      end

      assign wrap_nx = ~clr_i[c] & inc_eff & (&bin_q[ADDR_W-1:0]);

`ifdef GRAY_PTR_ALMOST_EN
      logic [PW-1:0] rbin;
      logic [PW-1:0] level;

      always_comb begin
        rbin[PW-1] = rptr[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
          rbin[i] = rbin[i+1] ^ rptr[i];
        end
      end

      always_comb begin
        if (MODE == 0) begin
          level  = bin_nx - rbin;
          alm_nx = (level >= PW'((1 << ADDR_W) - ALMOST_TH));
        end else begin
          level  = rbin - bin_nx;
          alm_nx = (level <= PW'(ALMOST_TH));
        end
      end
`else
      assign alm_nx = 1'b0;
`endif

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          bin_q  <= '0;
          gray_q <= '0;
          flag_q <= FLAG_RST;
          wrap_q <= 1'b0;
          alm_q  <= 1'b0;
        end else begin
          bin_q  <= bin_nx;
          gray_q <= gray_nx;
          flag_q <= flag_nx;
          wrap_q <= wrap_nx;
          alm_q  <= alm_nx;
        end
      end

      assign addr_o[c*ADDR_W +: ADDR_W] = bin_q[ADDR_W-1:0];
      assign ptr_o[c*PW +: PW]          = gray_q;
      assign next_ptr_o[c*PW +: PW]     = gray_nx;
      assign flag_o[c]                  = flag_q;
      assign wrap_o[c]                  = wrap_q;
      assign almost_o[c]                = alm_q;
    end
  endgenerate

endmodule

// File: tb/tb_gray_ptr_bank.sv
// Bench for gray_ptr_bank: write-side 2-channel and read-side 1-channel
// instances checked against a lap/level model plus directed vectors.
module tb_gray_ptr_bank;

`ifdef GRAY_PTR_ALMOST_EN
  localparam bit ALM_EN = 1'b1;
`else
  localparam bit ALM_EN = 1'b0;
`endif
  localparam int TH = 1;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] inc0, en0, clr0;
  logic [7:0] rptr0;
  logic [5:0] addr0;
  logic [7:0] ptr0, nptr0;
  logic [1:0] flag0, wrap0, alm0;
  logic       inc1, en1, clr1;
  logic [3:0] rptr1;
  logic [2:0] addr1;
  logic [3:0] ptr1, nptr1;
  logic       flag1, wrap1, alm1;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  gray_ptr_bank #(.ADDR_W(3), .CHANNELS(2), .MODE(0), .ALMOST_TH(TH)) u0 (
    .clk(clk), .reset_n(reset_n), .inc_i(inc0), .en_i(en0), .clr_i(clr0),
    .rptr_i(rptr0), .addr_o(addr0), .ptr_o(ptr0), .next_ptr_o(nptr0),
    .flag_o(flag0), .wrap_o(wrap0), .almost_o(alm0));

  gray_ptr_bank #(.ADDR_W(3), .CHANNELS(1), .MODE(1), .ALMOST_TH(TH)) u1 (
    .clk(clk), .reset_n(reset_n), .inc_i(inc1), .en_i(en1), .clr_i(clr1),
    .rptr_i(rptr1), .addr_o(addr1), .ptr_o(ptr1), .next_ptr_o(nptr1),
    .flag_o(flag1), .wrap_o(wrap1), .almost_o(alm1));

  // Model: index 0,1 = u0 channels (write side), 2 = u1 (read side)
  int m_bin[3];
  bit m_flag[3], m_wrap[3], m_alm[3];
  int rb[3];

  function automatic int gray(input int b);
    return (b ^ (b >> 1)) & 15;
  endfunction

  function automatic int g2b(input int g);
    for (int i = 0; i < 16; i++) if (gray(i) == g) return i;
    return 0;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_bin[i] = 0; m_flag[i] = (i == 2); m_wrap[i] = 0; m_alm[i] = 0;
      rb[i] = 0;
    end
  endtask

  task automatic get_in(input int i, output bit inc, output bit en,
                        output bit clr, output int rp);
    if (i < 2) begin
      inc = inc0[i]; en = en0[i]; clr = clr0[i]; rp = int'(rptr0[i*4 +: 4]);
    end else begin
      inc = inc1; en = en1; clr = clr1; rp = int'(rptr1);
    end
  endtask

  task automatic chk_regs();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("addr0[%0d]", i), int'(addr0[i*3 +: 3]), m_bin[i] % 8);
      chk($sformatf("ptr0[%0d]", i), int'(ptr0[i*4 +: 4]), gray(m_bin[i]));
      chk($sformatf("full0[%0d]", i), int'(flag0[i]), int'(m_flag[i]));
      chk($sformatf("wrap0[%0d]", i), int'(wrap0[i]), int'(m_wrap[i]));
      chk($sformatf("alm0[%0d]", i), int'(alm0[i]), int'(m_alm[i]));
    end
    chk("addr1", int'(addr1), m_bin[2] % 8);
    chk("ptr1", int'(ptr1), gray(m_bin[2]));
    chk("empty1", int'(flag1), int'(m_flag[2]));
    chk("wrap1", int'(wrap1), int'(m_wrap[2]));
    chk("alm1", int'(alm1), int'(m_alm[2]));
  endtask

  // Inputs are set at the falling edge before calling step
  task automatic step();
    int bn[3];
    bit fn[3], wn[3], an[3];
    bit inc, en, clr, ie;
    int rp, r, lvl;
    #1;
    for (int i = 0; i < 3; i++) begin
      get_in(i, inc, en, clr, rp);
      ie = inc && en && !m_flag[i];
      bn[i] = clr ? 0 : (m_bin[i] + int'(ie)) % 16;
      r = g2b(rp);
      if (i < 2) begin
        lvl = (bn[i] - r + 16) % 16;
        fn[i] = (lvl == 8);
        an[i] = ALM_EN && (lvl >= 8 - TH);
      end else begin
        lvl = (r - bn[i] + 16) % 16;
        fn[i] = (lvl == 0);
        an[i] = ALM_EN && (lvl <= TH);
      end
      wn[i] = !clr && ie && (m_bin[i] % 8 == 7);
    end
    chk("nptr0[0]", int'(nptr0[3:0]), gray(bn[0]));
    chk("nptr0[1]", int'(nptr0[7:4]), gray(bn[1]));
    chk("nptr1", int'(nptr1), gray(bn[2]));
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      m_bin[i] = bn[i]; m_flag[i] = fn[i]; m_wrap[i] = wn[i]; m_alm[i] = an[i];
    end
    @(negedge clk);
    chk_regs();
  endtask

  task automatic idle_inputs();
    inc0 = '0; en0 = '1; clr0 = '0; rptr0 = '0;
    inc1 = 1'b0; en1 = 1'b1; clr1 = 1'b0; rptr1 = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    idle_inputs();
    model_reset();
    #1;
    chk_regs();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  typedef struct {
    logic       inc;
    logic [3:0] rptr;
    logic [2:0] addr;
    logic [3:0] ptr;
    logic       flag;
    logic       wrap;
  } vec_t;

  vec_t tbl[10];
  int   nwrap;

  initial begin
    tbl[0] = '{1'b1, 4'h0, 3'd1, 4'h1, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 4'h0, 3'd2, 4'h3, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 4'h0, 3'd3, 4'h2, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 4'h0, 3'd4, 4'h6, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 4'h0, 3'd5, 4'h7, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 4'h0, 3'd6, 4'h5, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 4'h0, 3'd7, 4'h4, 1'b0, 1'b0};
    tbl[7] = '{1'b1, 4'h0, 3'd0, 4'hC, 1'b1, 1'b1};
    tbl[8] = '{1'b1, 4'h0, 3'd0, 4'hC, 1'b1, 1'b0};
    tbl[9] = '{1'b1, 4'h0, 3'd0, 4'hC, 1'b1, 1'b0};

    idle_inputs();
    model_reset();
    do_reset();

    // Fill channel 0 to full; channel 1 held in clear
    for (int k = 0; k < 10; k++) begin
      inc0 = {1'b1, tbl[k].inc};
      clr0 = 2'b10;
      rptr0 = {4'h0, tbl[k].rptr};
      step();
      chk($sformatf("tbl_addr%0d", k), int'(addr0[2:0]), int'(tbl[k].addr));
      chk($sformatf("tbl_ptr%0d", k), int'(ptr0[3:0]), int'(tbl[k].ptr));
      chk($sformatf("tbl_full%0d", k), int'(flag0[0]), int'(tbl[k].flag));
      chk($sformatf("tbl_wrap%0d", k), int'(wrap0[0]), int'(tbl[k].wrap));
      chk($sformatf("tbl_alm%0d", k), int'(alm0[0]), int'(ALM_EN && k >= 6));
      chk($sformatf("tbl_ch1_%0d", k), int'(ptr0[7:4]), 0);
    end

    // Clear while full drops the flag
    clr0 = 2'b11; inc0 = 2'b00;
    step();
    chk("clr_full", int'(flag0[0]), 0);

    // Clear beats increment at address 5; en=0 blocks increment
    clr0 = 2'b00; inc0 = 2'b01;
    for (int k = 0; k < 5; k++) step();
    chk("pre_clr_addr", int'(addr0[2:0]), 5);
    clr0 = 2'b01;
    step();
    chk("clr_addr", int'(addr0[2:0]), 0);
    chk("clr_ptr", int'(ptr0[3:0]), 0);
    chk("clr_wrap", int'(wrap0[0]), 0);
    clr0 = 2'b00; en0 = 2'b10;
    step();
    chk("en_off_addr", int'(addr0[2:0]), 0);
    en0 = 2'b11;

    // Read side: empty out of reset, tracks remote write pointer
    do_reset();
    chk("rd_rst_empty", int'(flag1), 1);
    rptr1 = 4'h1;
    step();
    chk("rd_not_empty", int'(flag1), 0);
    inc1 = 1'b1;
    step();
    chk("rd_ptr", int'(ptr1), 1);
    chk("rd_empty", int'(flag1), 1);
    inc1 = 1'b0;

    // 16 increments with the remote pointer trailing: two wraps
    do_reset();
    nwrap = 0;
    inc0 = 2'b01;
    for (int k = 0; k < 16; k++) begin
      rptr0 = {4'h0, 4'(gray(m_bin[0]))};
      step();
      nwrap += int'(wrap0[0]);
      if (k == 7) chk("wrapbit_hi", int'(ptr0[3]), 1);
    end
    chk("wrap_count", nwrap, 2);
    chk("wrapbit_lo", int'(ptr0[3]), 0);

    // Randomised traffic on all channels
    do_reset();
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < 3; i++) begin
        if ($urandom_range(1) == 1) begin
          if (i < 2 && rb[i] != m_bin[i]) rb[i] = (rb[i] + 1) % 16;
          if (i == 2 && ((rb[i] - m_bin[i] + 16) % 16) < 8) rb[i] = (rb[i] + 1) % 16;
        end
      end
      inc0 = 2'($urandom);
      en0 = {($urandom_range(7) != 0), ($urandom_range(7) != 0)};
      clr0 = {($urandom_range(40) == 0), ($urandom_range(40) == 0)};
      rptr0 = {4'(gray(rb[1])), 4'(gray(rb[0]))};
      inc1 = 1'($urandom);
      en1 = ($urandom_range(7) != 0);
      clr1 = ($urandom_range(40) == 0);
      rptr1 = 4'(gray(rb[2]));
      step();
    end

    // Asynchronous reset in the middle of counting
    idle_inputs();
    inc0 = 2'b11; inc1 = 1'b1; rptr1 = 4'h6;
    for (int k = 0; k < 3; k++) step();
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    chk_regs();
    chk("async_addr", int'(addr0), 0);
    @(negedge clk);
    reset_n = 1'b1;
    idle_inputs();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
